// File: rtl/controlpack.sv
// Shared control encodings for the register file and the control unit.
package controlpack;

  typedef enum logic [1:0] {
    REG_OP_NOP   = 2'd0,
    REG_OP_LOAD  = 2'd1,
    REG_OP_CLEAR = 2'd2,
    REG_OP_INC   = 2'd3
  } registers_op_e;

  typedef enum logic [2:0] {
    REG_R0 = 3'd0,
    REG_R1 = 3'd1,
    REG_R2 = 3'd2,
    REG_R3 = 3'd3,
    REG_R4 = 3'd4,
    REG_R5 = 3'd5,
    REG_R6 = 3'd6,
    REG_R7 = 3'd7
  } register_sel_e;

  localparam int unsigned NUM_REGS = 8;

endpackage

// File: rtl/register_file.sv
// Eight-entry register file: one synchronous modify port, two combinational reads.
module register_file
  import controlpack::*;
#(
  parameter int DATA_BUS_WIDTH = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  registers_op_e             op,
  input  register_sel_e             reg_in_sel,
  input  register_sel_e             reg_1_out_sel,
  input  register_sel_e             reg_2_out_sel,
  input  logic [DATA_BUS_WIDTH-1:0] reg_data_in,
  output logic [DATA_BUS_WIDTH-1:0] reg_1_out,
  output logic [DATA_BUS_WIDTH-1:0] reg_2_out
);

  logic [DATA_BUS_WIDTH-1:0] regs [NUM_REGS];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      unique case (op)
        REG_OP_NOP:   ;
        REG_OP_LOAD:  regs[reg_in_sel] <= reg_data_in;
        REG_OP_CLEAR: regs[reg_in_sel] <= '0;
        REG_OP_INC:   regs[reg_in_sel] <= regs[reg_in_sel] + 1'b1;
        default:      ;
      endcase
    end
  end

  // No write bypass: reads see the stored value until the edge.
  assign reg_1_out = regs[reg_1_out_sel];
  assign reg_2_out = regs[reg_2_out_sel];

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
module tb_register_file;
  import controlpack::*;

  logic          clock;
  logic          reset;
  registers_op_e op;
  register_sel_e reg_in_sel;
  register_sel_e reg_1_out_sel;
  register_sel_e reg_2_out_sel;
  logic [7:0]    reg_data_in;
  logic [7:0]    reg_1_out;
  logic [7:0]    reg_2_out;

  int passed;
  int total;

  register_file #(.DATA_BUS_WIDTH(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .op           (op),
    .reg_in_sel   (reg_in_sel),
    .reg_1_out_sel(reg_1_out_sel),
    .reg_2_out_sel(reg_2_out_sel),
    .reg_data_in  (reg_data_in),
    .reg_1_out    (reg_1_out),
    .reg_2_out    (reg_2_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
  endtask

  // Apply one op across a rising edge, then return to NOP.
  task automatic do_op(input registers_op_e o, input int sel, input logic [7:0] d);
    op          = o;
    reg_in_sel  = register_sel_e'(sel);
    reg_data_in = d;
    @(posedge clock);
    #1;
    op = REG_OP_NOP;
  endtask

  task automatic read2(input int s1, input int s2);
    reg_1_out_sel = register_sel_e'(s1);
    reg_2_out_sel = register_sel_e'(s2);
    #1;
  endtask

  function automatic logic [7:0] loaded(input int i);
    logic [7:0] v;
    v = (i == 7) ? 8'hA5 : 8'(17 * (i + 1));
    return v;
  endfunction

  initial begin
    passed        = 0;
    total         = 0;
    reset         = 1'b0;
    op            = REG_OP_LOAD;
    reg_in_sel    = REG_R3;
    reg_1_out_sel = REG_R3;
    reg_2_out_sel = REG_R0;
    reg_data_in   = 8'hEE;

    // Edges while reset is held must not load anything.
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("held_reset_r3", reg_1_out, 8'h00);
    op    = REG_OP_NOP;
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      read2(i, 7 - i);
      check($sformatf("reset_p1_r%0d", i), reg_1_out, 8'h00);
      check($sformatf("reset_p2_r%0d", 7 - i), reg_2_out, 8'h00);
    end

    @(negedge clock);
    for (int i = 0; i < 8; i++) do_op(REG_OP_LOAD, i, loaded(i));
    for (int i = 0; i < 8; i++) begin
      read2(i, (i + 3) % 8);
      check($sformatf("load_p1_r%0d", i), reg_1_out, loaded(i));
      check($sformatf("load_p2_r%0d", (i + 3) % 8), reg_2_out, loaded((i + 3) % 8));
    end
    read2(3, 7);
    check("load_r3", reg_1_out, 8'h44);
    check("load_r7", reg_2_out, 8'hA5);

    // Read during write.
    do_op(REG_OP_LOAD, 2, 8'h10);
    read2(2, 3);
    op          = REG_OP_LOAD;
    reg_in_sel  = REG_R2;
    reg_data_in = 8'h3C;
    #1;
    check("rdw_before", reg_1_out, 8'h10);
    @(posedge clock);
    #1;
    op = REG_OP_NOP;
    check("rdw_after", reg_1_out, 8'h3C);
    check("rdw_other_r3", reg_2_out, 8'h44);

    // Increment wrap.
    do_op(REG_OP_LOAD, 5, 8'hFE);
    do_op(REG_OP_INC, 5, 8'h00);
    read2(5, 4);
    check("inc_ff", reg_1_out, 8'hFF);
    do_op(REG_OP_INC, 5, 8'h00);
    read2(5, 4);
    check("inc_wrap", reg_1_out, 8'h00);
    check("inc_r4_kept", reg_2_out, 8'h55);
    read2(6, 4);
    check("inc_r6_kept", reg_1_out, 8'h77);

    // NOP holds, CLEAR zeroes.
    do_op(REG_OP_LOAD, 1, 8'h77);
    for (int k = 0; k < 3; k++) do_op(REG_OP_NOP, 1, 8'hFF);
    read2(1, 0);
    check("nop_hold_r1", reg_1_out, 8'h77);
    do_op(REG_OP_CLEAR, 1, 8'hFF);
    read2(1, 0);
    check("clear_r1", reg_1_out, 8'h00);
    check("clear_r0_kept", reg_2_out, 8'h11);

    // Asynchronous reset mid-operation.
    do_op(REG_OP_LOAD, 0, 8'h55);
    read2(0, 7);
    check("pre_async_r0", reg_1_out, 8'h55);
    op          = REG_OP_LOAD;
    reg_in_sel  = REG_R0;
    reg_data_in = 8'h99;
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("async_r0_now", reg_1_out, 8'h00);
    check("async_r7_now", reg_2_out, 8'h00);
    @(posedge clock);
    #1;
    check("async_r0_edge", reg_1_out, 8'h00);
    op    = REG_OP_NOP;
    reset = 1'b1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
